sigma_rf_datapath: RTL
======================

SIGMA_RF_DATAPATH -- requirements
Module: sigma_rf_datapath

Interface
REQ-001 SHALL have parameter N, default 32, data width in bits (N >= 4).
REQ-002 SHALL have parameter R, default 4, register count, power of two, R >= 2; LR = log2(R).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  microinstruction offered.
REQ-006 SHALL have port in_ready  output  1  block accepts a microinstruction this cycle.
REQ-007 SHALL have port op  input  3  000 LOAD, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 MOV, 110 MUL, 111 NOP.
REQ-008 SHALL have ports dst, srca, srcb  input  LR each  destination and source register indices.
REQ-009 SHALL have port X  input  N  external operand for LOAD.
REQ-010 SHALL have port out_valid  output  1  one-cycle pulse, operation completed.
REQ-011 SHALL have port result  output  N  value written by the last completed operation.
REQ-012 SHALL have ports zero, neg, carry  output  1 each  status flags.
REQ-013 SHALL have ports rd_sel  input  LR, and rd_data  output  N; rd_data is combinational contents of register rd_sel.

Function
REQ-014 Accept SHALL occur on a rising edge where in_valid=1 and in_ready=1; op, dst, srca, srcb and X are sampled only at accept.
REQ-015 States SHALL be IDLE and MUL; in_ready=1 exactly when state is IDLE and reset=0.
REQ-016 Non-MUL ops SHALL complete at the accept edge: dst written (except NOP), result, flags and out_valid=1 registered; out_valid is high for the single cycle after accept.
REQ-017 LOAD: dst<=X. ADD: dst<=Ra+Rb mod 2^N. SUB: dst<=Ra-Rb mod 2^N. AND/OR bitwise. MOV: dst<=Ra. NOP: no register write, result holds its previous value, flags hold.
REQ-018 Operands SHALL be the register values before the edge; dst equal to srca and/or srcb is legal.
REQ-019 MUL SHALL be iterative shift-add, unsigned, low N bits of Ra*Rb; accept moves state IDLE->MUL and latches operands; N further edges iterate; on the Nth, dst, result, flags are written, out_valid=1 in the following cycle, and state returns to IDLE.
REQ-020 in_valid during MUL SHALL be ignored; a back-to-back op may be accepted in the cycle out_valid is high.
REQ-021 Flags SHALL update on every completing op except NOP: zero=(result==0), neg=result[N-1]; carry = ADD carry-out, SUB borrow (Ra<Rb unsigned), 0 for all other ops.
REQ-022 out_valid SHALL be 0 in every cycle not covered by REQ-016/REQ-019.

Reset
REQ-023 While reset=1 at an edge: all R registers<=0, result<=0, zero/neg/carry<=0, out_valid<=0, state<=IDLE, iteration counter<=0.
REQ-024 Reset SHALL take priority over accept and over MUL completion; reset during MUL aborts with no register write.
REQ-025 in_ready SHALL be 0 while reset=1 and 1 in the first cycle after reset deasserts.

Verification (N=8, R=4)
REQ-026 LOAD r1<-0x05, LOAD r2<-0x03, ADD r3=r1+r2 -> result 0x08 one cycle after accept, zero=0 neg=0 carry=0, rd_sel=3 gives 0x08.
REQ-027 SUB r0=r2-r1 (0x03-0x05) -> 0xFE, neg=1, carry=1, zero=0.
REQ-028 LOAD r1<-0xFF, r2<-0x01, ADD r3=r1+r2 -> 0x00, zero=1, carry=1; then NOP -> out_valid pulse, flags and result unchanged.
REQ-029 r1=0x0C, r2=0x0B, MUL r3 -> in_ready low 8 cycles, in_valid ADD offered meanwhile ignored, out_valid 8 cycles later than for ADD, result 0x84, neg=1.
REQ-030 Reset asserted on 4th MUL iteration -> all registers 0, out_valid never pulses, in_ready=1 after release.
REQ-031 r1=0x05, ADD r1=r1+r1 -> 0x0A; follow-up ADD r1=r1+r1 accepted back-to-back -> 0x14.

Source files
------------

// File: rtl/sigma_rf_datapath.sv
// Register-file datapath: single-cycle ALU ops plus an N-iteration shift-add multiplier.
// One microinstruction is accepted per handshake; MUL holds off new work until it completes.
module sigma_rf_datapath #(
  parameter  int N  = 32,
  parameter  int R  = 4,
  localparam int LR = $clog2(R)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [LR-1:0] dst,
  input  logic [LR-1:0] srca,
  input  logic [LR-1:0] srcb,
  input  logic [N-1:0]  X,
  output logic          out_valid,
  output logic [N-1:0]  result,
  output logic          zero,
  output logic          neg,
  output logic          carry,
  input  logic [LR-1:0] rd_sel,
  output logic [N-1:0]  rd_data
);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_MOV  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;
  localparam int CW = $clog2(N);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t              r_state, w_state_nxt;
  logic [R-1:0][N-1:0] r_regs;
  logic [N-1:0]        r_result;
  logic                r_zero, r_neg, r_carry, r_out_valid;
  logic [N-1:0]        r_mcand, r_mplier, r_acc;
  logic [LR-1:0]       r_dst;
  logic [CW-1:0]       r_cnt;

  logic [N-1:0]        w_ra, w_rb, w_alu, w_acc_nxt;
  logic [N:0]          w_sum, w_dif;
  logic                w_cy, w_accept, w_mul_last;

  always_comb begin
    w_ra  = r_regs[srca];
    w_rb  = r_regs[srcb];
    w_sum = {1'b0, w_ra} + {1'b0, w_rb};
    w_dif = {1'b0, w_ra} - {1'b0, w_rb};
    w_alu = '0;
    w_cy  = 1'b0;
    case (op)
      OP_LOAD: w_alu = X;
      OP_ADD:  begin w_alu = w_sum[N-1:0]; w_cy = w_sum[N]; end
      OP_SUB:  begin w_alu = w_dif[N-1:0]; w_cy = w_dif[N]; end
      OP_AND:  w_alu = w_ra & w_rb;
      OP_OR:   w_alu = w_ra | w_rb;
      OP_MOV:  w_alu = w_ra;
      default: w_alu = '0;
    endcase
  end

  // one shift-add step: add the shifted multiplicand when the current multiplier LSB is set
  assign w_acc_nxt  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mul_last = (r_cnt == CW'(N-1));

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = (r_state == S_IDLE) && !reset;
    w_accept    = in_valid && in_ready;
    case (r_state)
      S_IDLE:  if (w_accept && op == OP_MUL) w_state_nxt = S_MUL;
      S_MUL:   if (w_mul_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_regs      <= '0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_carry     <= 1'b0;
      r_out_valid <= 1'b0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_dst       <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= 1'b0;
      if (w_accept) begin
        if (op == OP_MUL) begin
          r_mcand  <= w_ra;
          r_mplier <= w_rb;
          r_acc    <= '0;
          r_cnt    <= '0;
          r_dst    <= dst;
        end else begin
          r_out_valid <= 1'b1;
          if (op != OP_NOP) begin
            r_regs[dst] <= w_alu;
            r_result    <= w_alu;
            r_zero      <= (w_alu == '0);
            r_neg       <= w_alu[N-1];
            r_carry     <= w_cy;
          end
        end
      end else if (r_state == S_MUL) begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        if (w_mul_last) begin
          r_regs[r_dst] <= w_acc_nxt;
          r_result      <= w_acc_nxt;
          r_zero        <= (w_acc_nxt == '0);
          r_neg         <= w_acc_nxt[N-1];
          r_carry       <= 1'b0;
          r_out_valid   <= 1'b1;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign neg       = r_neg;
  assign carry     = r_carry;
  assign rd_data   = r_regs[rd_sel];

endmodule
